// File: rtl/wbpipe_ram.sv
// Pipelined Wishbone slave backed by block RAM. Takes one request per clock and
// answers each with an ack (or err for out-of-range addresses) LATENCY clocks later, in order.
module wbpipe_ram #(
    parameter int AW       = 24,
    parameter int LGMEMSZ  = 10,
    parameter int MEMWORDS = 1024,
    parameter int LATENCY  = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wb_cyc,
    input  logic          i_wb_stb,
    input  logic          i_wb_we,
    input  logic [AW-1:0] i_wb_addr,
    input  logic [31:0]   i_wb_data,
    input  logic          i_hold,
    output logic          o_wb_stall,
    output logic          o_wb_ack,
    output logic          o_wb_err,
    output logic [31:0]   o_wb_data,
    output logic          o_busy
);
    localparam int DEPTH = 1 << LGMEMSZ;
    localparam logic [AW-1:0] MEM_LIMIT = AW'(MEMWORDS);

    logic [31:0]        mem_r [0:DEPTH-1];
    logic [31:0]        dat_r [0:LATENCY-1];
    logic [LATENCY-1:0] vld_r;
    logic [LATENCY-1:0] we_r;
    logic [LATENCY-1:0] err_r;
    logic               err_pend_r;
    logic [31:0]        last_r;

    logic               accept_s;
    logic               in_range_s;
    logic               rd_ack_s;
    logic [LGMEMSZ-1:0] idx_s;

    assign o_wb_stall = i_hold | err_pend_r;
    assign accept_s   = i_wb_cyc & i_wb_stb & ~o_wb_stall;
    assign in_range_s = (i_wb_addr < MEM_LIMIT);
    assign idx_s      = i_wb_addr[LGMEMSZ-1:0];

    // Responses leave the last stage; a dropped cycle suppresses them outright.
    assign o_wb_ack  = vld_r[LATENCY-1] & ~err_r[LATENCY-1] & i_wb_cyc;
    assign o_wb_err  = vld_r[LATENCY-1] &  err_r[LATENCY-1] & i_wb_cyc;
    assign rd_ack_s  = o_wb_ack & ~we_r[LATENCY-1];
    assign o_wb_data = rd_ack_s ? dat_r[LATENCY-1] : last_r;
    assign o_busy    = |vld_r;

    // RAM write port; out-of-range requests and reset cycles never touch the array.
    always_ff @(posedge i_clk) begin
        if (accept_s && i_wb_we && in_range_s && !i_rst) begin
            mem_r[idx_s] <= i_wb_data;
        end
    end

    // Synchronous RAM read followed by the read-data delay line.
    always_ff @(posedge i_clk) begin
        if (accept_s && !i_wb_we && in_range_s) begin
            dat_r[0] <= mem_r[idx_s];
        end
        for (int k = 1; k < LATENCY; k++) begin
            dat_r[k] <= dat_r[k-1];
        end
    end

    // Per-request attributes; only meaningful where the matching valid bit is set.
    always_ff @(posedge i_clk) begin
        we_r[0]  <= i_wb_we;
        err_r[0] <= ~in_range_s;
        for (int k = 1; k < LATENCY; k++) begin
            we_r[k]  <= we_r[k-1];
            err_r[k] <= err_r[k-1];
        end
    end

    // Valid pipeline, error-pending stall and the held read-data value.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_r      <= {LATENCY{1'b0}};
            err_pend_r <= 1'b0;
            last_r     <= 32'd0;
        end else begin
            vld_r[0] <= accept_s;
            for (int k = 1; k < LATENCY; k++) begin
                vld_r[k] <= vld_r[k-1] & i_wb_cyc;
            end
            if (!i_wb_cyc) begin
                err_pend_r <= 1'b0;
            end else if (accept_s && !in_range_s) begin
                err_pend_r <= 1'b1;
            end else if (o_wb_err) begin
                err_pend_r <= 1'b0;
            end else begin
                err_pend_r <= err_pend_r;
            end
            if (rd_ack_s) begin
                last_r <= dat_r[LATENCY-1];
            end
        end
    end
endmodule
